// File: rtl/axi_addr_remapper.sv
// axi_addr_remapper
//   Translates AXI AW and AR addresses through NUM_REGIONS runtime-programmable
//   windows (base/mask/offset/enable). Each address channel goes through a
//   registered two-entry skid slice: one cycle of latency, one beat per cycle
//   sustained. W, R and B are not handled here.
//
//   Region i hits when en_i && ((addr & mask_i) == base_i). The lowest hitting
//   index wins. On a hit, out = (addr & ~mask_i) | (offset_i & mask_i). On a
//   miss, the address passes through unchanged. The translation is taken on the
//   accept cycle and stored with the beat, so a later config write does not
//   change a beat that is already buffered.
//
// Ports
//   coreclk, corersts           clock, synchronous active-high reset
//   s_axi_aw*/m_axi_aw*         AW upstream / downstream (valid, ready, addr, meta)
//   s_axi_ar*/m_axi_ar*         AR upstream / downstream (valid, ready, addr, meta)
//   cfg_wen/cfg_idx/cfg_field/cfg_wdata
//                               region write port: field 0=base 1=mask 2=offset
//                               3=enable (cfg_wdata[0])
//   Optional, with AXI_ADDR_REMAPPER_STATS_EN defined:
//   stats_clr                   zeroes both miss counters (wins over increment)
//   aw_miss_cnt, ar_miss_cnt    saturating counts of accepted beats that miss

module axi_addr_remapper_slice #(
  parameter int unsigned DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              accept, drain;
  logic              load_main_in, load_main_skid, load_skid;

  // Both handshake outputs come straight from the state register, so there is
  // no combinational path from m_ready to s_ready.
  assign s_ready = (state != TWO);
  assign m_valid = (state != EMPTY);
  assign m_data  = main_q;
  assign accept  = s_valid && s_ready;
  assign drain   = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= s_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= s_data;
    end
  end

endmodule

module axi_addr_remapper #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned META_W      = 32,
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              coreclk,
  input  logic              corersts,

  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [META_W-1:0] s_axi_awmeta,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [META_W-1:0] m_axi_awmeta,

  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [META_W-1:0] s_axi_armeta,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [META_W-1:0] m_axi_armeta,

`ifdef AXI_ADDR_REMAPPER_STATS_EN
  input  logic              stats_clr,
  output logic [31:0]       aw_miss_cnt,
  output logic [31:0]       ar_miss_cnt,
`endif

  input  logic              cfg_wen,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [1:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_wdata
);

  logic [ADDR_W-1:0]      base_q   [NUM_REGIONS];
  logic [ADDR_W-1:0]      mask_q   [NUM_REGIONS];
  logic [ADDR_W-1:0]      offset_q [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] en_q;

  logic [ADDR_W-1:0]      aw_xaddr, ar_xaddr;

`ifdef AXI_ADDR_REMAPPER_STATS_EN
  logic                   aw_miss, ar_miss;
  logic [31:0]            aw_miss_q, ar_miss_q;
`endif

  // Region registers. A write here is seen by the translation only from the
  // following cycle, which gives the "cycle N+1 or later" config timing.
  always_ff @(posedge coreclk) begin
    if (corersts) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]   <= '0;
        mask_q[i]   <= '0;
        offset_q[i] <= '0;
      end
      en_q <= '0;
    end else if (cfg_wen) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          case (cfg_field)
            2'd0:    base_q[i]   <= cfg_wdata;
            2'd1:    mask_q[i]   <= cfg_wdata;
            2'd2:    offset_q[i] <= cfg_wdata;
            default: en_q[i]     <= cfg_wdata[0];
          endcase
        end
      end
    end
  end

  // Priority match: the found flags stop later (higher) regions from
  // overriding an earlier hit.
  always_comb begin : xlat
    logic aw_found;
    logic ar_found;
    aw_found = 1'b0;
    ar_found = 1'b0;
    aw_xaddr = s_axi_awaddr;
    ar_xaddr = s_axi_araddr;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!aw_found && en_q[i] && ((s_axi_awaddr & mask_q[i]) == base_q[i])) begin
        aw_found = 1'b1;
        aw_xaddr = (s_axi_awaddr & ~mask_q[i]) | (offset_q[i] & mask_q[i]);
      end
      if (!ar_found && en_q[i] && ((s_axi_araddr & mask_q[i]) == base_q[i])) begin
        ar_found = 1'b1;
        ar_xaddr = (s_axi_araddr & ~mask_q[i]) | (offset_q[i] & mask_q[i]);
      end
    end
`ifdef AXI_ADDR_REMAPPER_STATS_EN
    aw_miss = !aw_found;
    ar_miss = !ar_found;
`endif
  end

  axi_addr_remapper_slice #(
    .DATA_W (META_W + ADDR_W)
  ) u_aw_slice (
    .clk     (coreclk),
    .rst     (corersts),
    .s_valid (s_axi_awvalid),
    .s_ready (s_axi_awready),
    .s_data  ({s_axi_awmeta, aw_xaddr}),
    .m_valid (m_axi_awvalid),
    .m_ready (m_axi_awready),
    .m_data  ({m_axi_awmeta, m_axi_awaddr})
  );

  axi_addr_remapper_slice #(
    .DATA_W (META_W + ADDR_W)
  ) u_ar_slice (
    .clk     (coreclk),
    .rst     (corersts),
    .s_valid (s_axi_arvalid),
    .s_ready (s_axi_arready),
    .s_data  ({s_axi_armeta, ar_xaddr}),
    .m_valid (m_axi_arvalid),
    .m_ready (m_axi_arready),
    .m_data  ({m_axi_armeta, m_axi_araddr})
  );

`ifdef AXI_ADDR_REMAPPER_STATS_EN
  always_ff @(posedge coreclk) begin
    if (corersts || stats_clr) begin
      aw_miss_q <= '0;
      ar_miss_q <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready && aw_miss && (aw_miss_q != '1)) begin
        aw_miss_q <= aw_miss_q + 32'd1;
      end
      if (s_axi_arvalid && s_axi_arready && ar_miss && (ar_miss_q != '1)) begin
        ar_miss_q <= ar_miss_q + 32'd1;
      end
    end
  end

  assign aw_miss_cnt = aw_miss_q;
  assign ar_miss_cnt = ar_miss_q;
`endif

endmodule
